euler_step_sequencer: RTL and testbench

- Controls the fixed-point Euler integration datapath: state registers in Q11.20 format (1 sign, 11 integer, 20 fractional bits) that are fed back through combinational/pipelined arithmetic.
- On start, loads the initial conditions, then runs N integration steps. Each step waits LATENCY cycles for the datapath to settle, then pulses the register enable.
- Generates a decimated sample strobe for the output/logging path, plus busy and done status for the host.

---
 rtl/euler_step_sequencer_pkg.sv | 21 ++
 rtl/euler_step_sequencer_settle_timer.sv | 28 ++
 rtl/euler_step_sequencer.sv | 142 ++++++++++++++
 tb/tb_euler_step_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/euler_step_sequencer_pkg.sv
// Shared definitions for the Euler integration controller and its datapath:
// sequencer state encoding and the Q11.20 fixed-point format constants.
package euler_step_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_UPDATE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int WORD_W = 32;
  localparam int INT_W  = 11;
  localparam int FRAC_W = 20;
  localparam logic [WORD_W-1:0] Q_ONE = 32'h0010_0000;

  // Settle timer width covers the full legal LATENCY range (1..255).
  localparam int SETTLE_W = 8;

endpackage

// File: rtl/euler_step_sequencer_settle_timer.sv
// Loadable down-counter that times the datapath settle window between updates.
// Stops at zero; o_zero flags terminal count.
module euler_step_sequencer_settle_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/euler_step_sequencer.sv
// Sequencer for the fixed-point Euler datapath: loads initial conditions,
// paces N register updates LATENCY cycles apart, and emits decimated samples.
//
// state  | meaning
// IDLE   | waiting for start
// INIT   | initial conditions loaded into the state registers
// SETTLE | datapath settling, LATENCY cycles
// UPDATE | state registers capture one Euler step
// DONE   | one-cycle completion pulse
module euler_step_sequencer
  import euler_step_sequencer_pkg::*;
#(
  parameter int ITER_W  = 16,
  parameter int DECIM_W = 8,
  parameter int LATENCY = 3
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [ITER_W-1:0] i_n_iter,
  input  logic [DECIM_W-1:0] i_decim,
  output logic              o_init_load,
  output logic              o_reg_en,
  output logic              o_sample_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic [ITER_W-1:0] o_iter_cnt
);

  state_e r_state;
  state_e w_next;

  logic [ITER_W-1:0]  r_n_iter;
  logic [DECIM_W-1:0] r_decim;
  logic [ITER_W-1:0]  r_iter_cnt;
  logic [DECIM_W-1:0] r_decim_cnt;

  logic               w_abort;
  logic               w_start_ok;
  logic               w_last_step;
  logic               w_decim_hit;
  logic [DECIM_W-1:0] w_decim_eff;
  logic               w_tmr_load;
  logic               w_tmr_dec;
  logic               w_tmr_zero;

  assign w_abort     = i_abort && (r_state != ST_IDLE);
  assign w_start_ok  = i_start && (r_state == ST_IDLE);
  assign w_last_step = ((r_iter_cnt + ITER_W'(1)) == r_n_iter);
  assign w_decim_eff = (r_decim == '0) ? DECIM_W'(1) : r_decim;
  assign w_decim_hit = (r_decim_cnt == (w_decim_eff - DECIM_W'(1)));
  assign w_tmr_load  = (r_state == ST_INIT) || (r_state == ST_UPDATE);
  assign w_tmr_dec   = (r_state == ST_SETTLE);

  euler_step_sequencer_settle_timer #(
    .W (SETTLE_W)
  ) u_settle_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (SETTLE_W'(LATENCY - 1)),
    .i_dec      (w_tmr_dec),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next = (i_n_iter != '0) ? ST_INIT : ST_DONE;
        end
      end
      ST_INIT:   w_next = ST_SETTLE;
      ST_SETTLE: w_next = w_tmr_zero ? ST_UPDATE : ST_SETTLE;
      ST_UPDATE: w_next = w_last_step ? ST_DONE : ST_SETTLE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
    if (w_abort) begin
      w_next = ST_IDLE;
    end
  end

  // Abort must kill register writes in the very cycle it is seen.
  always_comb begin
    o_init_load    = 1'b0;
    o_reg_en       = 1'b0;
    o_sample_valid = 1'b0;
    o_busy         = 1'b0;
    o_done         = 1'b0;
    case (r_state)
      ST_INIT: begin
        o_init_load = !w_abort;
        o_reg_en    = !w_abort;
        o_busy      = 1'b1;
      end
      ST_SETTLE: o_busy = 1'b1;
      ST_UPDATE: begin
        o_reg_en       = !w_abort;
        o_sample_valid = !w_abort && w_decim_hit;
        o_busy         = 1'b1;
      end
      ST_DONE: o_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_n_iter    <= '0;
      r_decim     <= '0;
      r_iter_cnt  <= '0;
      r_decim_cnt <= '0;
    end else if (w_start_ok) begin
      r_n_iter    <= i_n_iter;
      r_decim     <= i_decim;
      r_iter_cnt  <= '0;
      r_decim_cnt <= '0;
    end else if (!w_abort) begin
      if (r_state == ST_INIT) begin
        r_iter_cnt  <= '0;
        r_decim_cnt <= '0;
      end else if (r_state == ST_UPDATE) begin
        r_iter_cnt  <= r_iter_cnt + ITER_W'(1);
        r_decim_cnt <= w_decim_hit ? '0 : (r_decim_cnt + DECIM_W'(1));
      end
    end
  end

  assign o_iter_cnt = r_iter_cnt;

endmodule

// File: tb/tb_euler_step_sequencer.sv
// Bench for euler_step_sequencer: cycle-by-cycle comparison against a timing
// model derived from the step schedule (INIT at c1, UPDATE k at 1+k*(L+1)).
module tb_euler_step_sequencer;

  localparam int LAT = 3;
  localparam int IW  = 16;
  localparam int DW  = 8;
  localparam int L1  = LAT + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [IW-1:0] n_iter;
  logic [DW-1:0] decim;
  logic          init_load, reg_en, sample_valid, busy, done;
  logic [IW-1:0] iter_cnt;

  int checks = 0;
  int errors = 0;

  euler_step_sequencer #(
    .ITER_W  (IW),
    .DECIM_W (DW),
    .LATENCY (LAT)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_abort        (abort),
    .i_n_iter       (n_iter),
    .i_decim        (decim),
    .o_init_load    (init_load),
    .o_reg_en       (reg_en),
    .o_sample_valid (sample_valid),
    .o_busy         (busy),
    .o_done         (done),
    .o_iter_cnt     (iter_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s c%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  // Expected outputs in cycle c of a run started at edge 0 (abort a, 0 = none).
  task automatic expect_c(input int c, input int n, input int de, input int a,
                          output logic il, output logic re, output logic sv,
                          output logic bz, output logic dn, output int it);
    int de_eff, last, endc, k;
    bit gate;
    de_eff = (de == 0) ? 1 : de;
    il = 0; re = 0; sv = 0; bz = 0; dn = 0;
    last = (a != 0 && c > a) ? a : c;
    it = 0;
    if (n > 0 && last >= 2) it = ((last - 2) / L1 < n) ? (last - 2) / L1 : n;
    if (a != 0 && c > a) return;
    gate = (c == a);
    if (n == 0) begin
      dn = (c == 1);
      return;
    end
    endc = 2 + n * L1;
    if (c == 1) begin
      bz = 1; il = !gate; re = !gate;
    end else if (c < endc) begin
      bz = 1;
      if ((c - 1) % L1 == 0) begin
        k  = (c - 1) / L1;
        re = !gate;
        sv = !gate && (k % de_eff == 0);
      end
    end else if (c == endc) begin
      dn = 1;
    end
  endtask

  task automatic check_cycle(input int c, input int n, input int de, input int a);
    logic il, re, sv, bz, dn;
    int it;
    expect_c(c, n, de, a, il, re, sv, bz, dn, it);
    chk("init_load",    c, {31'b0, init_load},    {31'b0, il});
    chk("reg_en",       c, {31'b0, reg_en},       {31'b0, re});
    chk("sample_valid", c, {31'b0, sample_valid}, {31'b0, sv});
    chk("busy",         c, {31'b0, busy},         {31'b0, bz});
    chk("done",         c, {31'b0, done},         {31'b0, dn});
    chk("iter_cnt",     c, 32'(iter_cnt),         32'(it));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_init_load"}, 0, {31'b0, init_load},    32'd0);
    chk({tag, "_reg_en"},    0, {31'b0, reg_en},       32'd0);
    chk({tag, "_sample"},    0, {31'b0, sample_valid}, 32'd0);
    chk({tag, "_busy"},      0, {31'b0, busy},         32'd0);
    chk({tag, "_done"},      0, {31'b0, done},         32'd0);
    chk({tag, "_iter_cnt"},  0, 32'(iter_cnt),         32'd0);
  endtask

  // Called just after a negedge. rs_c: cycle of a stray start with n_iter=rs_n.
  // rc: cycle in which reset is pulsed (run ends there).
  task automatic run(input int n, input int de, input int a,
                     input int rs_c, input int rs_n, input int rc);
    int total;
    if (n == 0)      total = 3;
    else if (a != 0) total = a + 2;
    else             total = 2 + n * L1 + 2;
    if (rc != 0) total = rc;
    start  = 1'b1;
    n_iter = IW'(n);
    decim  = DW'(de);
    for (int c = 1; c <= total; c++) begin
      @(posedge clk);
      #1;
      start = (c == rs_c);
      if (c == rs_c) n_iter = IW'(rs_n);
      else           n_iter = IW'($urandom);
      decim = DW'($urandom);
      abort = (a != 0 && c == a);
      if (c == rc) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("midrun_rst");
        @(negedge clk);
        rst_n = 1'b1;
        abort = 1'b0;
        start = 1'b0;
        return;
      end
      @(negedge clk);
      check_cycle(c, n, de, a);
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    int n, de, a;
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    n_iter = '0;
    decim  = '0;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run(4, 1, 0, 0, 0, 0);     // nominal
    run(4, 1, 0, 6, 2, 0);     // start while busy ignored
    run(0, 3, 0, 0, 0, 0);     // zero steps
    run(7, 3, 0, 0, 0, 0);     // decimation by 3
    run(7, 0, 0, 0, 0, 0);     // decim 0 acts as 1
    run(10, 1, 10, 0, 0, 0);   // abort in SETTLE of step 3
    run(6, 2, 9, 0, 0, 0);     // abort in UPDATE of step 2
    run(3, 1, 1, 0, 0, 0);     // abort in INIT

    abort = 1'b1;              // abort in IDLE has no effect
    repeat (2) begin
      @(negedge clk);
      chk("idle_abort_busy", 0, {31'b0, busy},   32'd0);
      chk("idle_abort_reg",  0, {31'b0, reg_en}, 32'd0);
      chk("idle_abort_done", 0, {31'b0, done},   32'd0);
    end
    abort = 1'b0;
    run(2, 1, 0, 0, 0, 0);

    run(5, 1, 0, 0, 0, 7);     // reset during SETTLE of step 2
    @(negedge clk);
    run(4, 1, 0, 0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      n  = $urandom_range(1, 8);
      de = $urandom_range(0, 5);
      a  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 1 + n * L1) : 0;
      run(n, de, a, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
